// File: rtl/gcd_arb_pkg.sv
// rtl/gcd_arb_pkg.sv - shared types and widths for the gcd_8 arbiter
package gcd_arb_pkg;

   localparam int GCD_W = 8;
   localparam int ID_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/gcd_8_arbiter_rr_arbiter.sv
// rtl/gcd_8_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] id
);

   logic found;

   // Scan positions ptr, ptr+1, ... with wrap; the first valid requester wins.
   always_comb begin
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j == (int'(ptr) + k) % N)) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               id     = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/gcd_8_arbiter.sv
// rtl/gcd_8_arbiter.sv - shares one gcd_8 datapath among N_REQ requesters
module gcd_8_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W       = GCD_W,
   parameter int GCD_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               rsp_valid,
   output logic [ID_W-1:0]    rsp_id,
   output logic [W-1:0]       rsp_gcd,
   input  logic               rsp_ready,
   output logic [W-1:0]       gcd_a,
   output logic [W-1:0]       gcd_b,
   input  logic [W-1:0]       gcd_out
);

   localparam int CNT_W = (GCD_LAT > 1) ? $clog2(GCD_LAT) : 1;

   state_e            state_q;
   logic [ID_W-1:0]   ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              rsp_valid_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [W-1:0]      rsp_gcd_q;
   logic [W-1:0]      gcd_a_q;
   logic [W-1:0]      gcd_b_q;

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;
   logic [W-1:0]      sel_a;
   logic [W-1:0]      sel_b;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .id  (gnt_id)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (gnt[j]) begin
            sel_a = req_a[j*W +: W];
            sel_b = req_b[j*W +: W];
         end
      end
   end

   assign req_ready = (state_q == IDLE) ? gnt : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_gcd_q   <= '0;
         gcd_a_q     <= '0;
         gcd_b_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt != '0) begin
                  gcd_a_q  <= sel_a;
                  gcd_b_q  <= sel_b;
                  rsp_id_q <= gnt_id;
                  ptr_q    <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                  // gcd(x,0) = x and gcd(0,0) = 0, so a|b is already the answer.
                  if (sel_a == '0 || sel_b == '0) begin
                     rsp_gcd_q   <= sel_a | sel_b;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     cnt_q   <= CNT_W'(GCD_LAT - 1);
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  rsp_gcd_q   <= gcd_out;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_gcd   = rsp_gcd_q;
   assign gcd_a     = gcd_a_q;
   assign gcd_b     = gcd_b_q;

endmodule

// File: tb/tb_gcd_8_arbiter.sv
// tb/tb_gcd_8_arbiter.sv - scoreboard bench for gcd_8_arbiter with a behavioural gcd_8
module tb_gcd_8_arbiter;

   localparam int N   = 4;
   localparam int LAT = 2;

   typedef struct {
      int         id;
      logic [7:0] g;
      int         due;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid;
   logic [N*8-1:0] req_a, req_b;
   logic [N-1:0]  req_ready;
   logic          rsp_valid;
   logic [2:0]    rsp_id;
   logic [7:0]    rsp_gcd;
   logic          rsp_ready = 1'b1;
   logic [7:0]    gcd_a, gcd_b;
   logic [7:0]    gcd_out = 8'd0;

   logic [N-1:0]  vld = '0;
   logic [7:0]    drv_a [N];
   logic [7:0]    drv_b [N];
   logic [7:0]    exp_val [N];

   ent_t sb[$];
   int   glog[$];
   int   hs_cnt [N];
   int   rsp_cnt [N];
   bit   busy = 0;
   bit   front_seen = 0;
   int   ptr_m = 0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   gcd_8_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_gcd   (rsp_gcd),
      .rsp_ready (rsp_ready),
      .gcd_a     (gcd_a),
      .gcd_b     (gcd_b),
      .gcd_out   (gcd_out)
   );

   function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // gcd_8 stand-in: result is present one edge after the operands and held until
   // the next edge, so an early or late capture by the arbiter sees a stale value.
   always @(posedge clk) gcd_out <= ref_gcd(gcd_a, gcd_b);

   always_comb begin
      req_valid = vld;
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         req_a[i*8 +: 8] = drv_a[i];
         req_b[i*8 +: 8] = drv_b[i];
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      int g;
      logic [N-1:0] er;
      ent_t e;
      cyc = cyc + 1;
      if (rst) begin
         sb.delete();
         busy = 0;
         ptr_m = 0;
         front_seen = 0;
      end else begin
         g  = rr_pick(req_valid, ptr_m);
         er = (!busy && g >= 0) ? N'(1 << g) : '0;
         check("req_ready", int'(req_ready), int'(er));
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_spurious", 1, 0);
            end else begin
               e = sb[0];
               if (!front_seen) begin
                  check("rsp_latency", cyc, e.due);
                  front_seen = 1;
               end
               check("rsp_id", int'(rsp_id), e.id);
               check("rsp_gcd", int'(rsp_gcd), int'(e.g));
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  rsp_cnt[e.id]++;
                  front_seen = 0;
                  busy = 0;
               end
            end
         end
         if ((req_valid & req_ready) != '0 && g >= 0) begin
            e.id  = g;
            e.g   = exp_val[g];
            e.due = cyc + ((drv_a[g] == 0 || drv_b[g] == 0) ? 1 : 1 + LAT);
            sb.push_back(e);
            busy = 1;
            ptr_m = (g + 1) % N;
            hs_cnt[g]++;
            glog.push_back(g);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
      drv_a[i] = a;
      drv_b[i] = b;
      exp_val[i] = e;
      vld[i] = 1'b1;
   endtask

   task automatic wait_hs(input int i, input int base);
      int n;
      n = 0;
      while (hs_cnt[i] == base && n < 200) begin
         tick();
         n++;
      end
      if (hs_cnt[i] == base) check("grant_timeout", 0, 1);
      vld[i] = 1'b0;
   endtask

   task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
      int base;
      base = hs_cnt[i];
      set_req(i, a, b, e);
      wait_hs(i, base);
   endtask

   task automatic drain;
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 500) begin
         tick();
         n++;
      end
      if (sb.size() != 0 || busy) check("drain_timeout", 0, 1);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_req_ready"}, int'(req_ready), 0);
      check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
      check({tag, "_rsp_id"}, int'(rsp_id), 0);
      check({tag, "_rsp_gcd"}, int'(rsp_gcd), 0);
      check({tag, "_gcd_a"}, int'(gcd_a), 0);
      check({tag, "_gcd_b"}, int'(gcd_b), 0);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int ord[5];
      int st, n, issued, got;
      int seen[N];
      int hs0[N];
      int rs0[N];
      logic [7:0] a, b;
      for (int i = 0; i < N; i++) begin
         drv_a[i] = 8'd0;
         drv_b[i] = 8'd0;
         exp_val[i] = 8'd0;
         hs_cnt[i] = 0;
         rsp_cnt[i] = 0;
      end
      #3;
      chk_zero("por");
      tick();
      rst = 1'b0;
      tick();

      // 1: reset while the job is in WAIT drops it silently
      issue(0, 8'd12, 8'd18, 8'd6);
      rst = 1'b1;
      #1;
      chk_zero("midjob");
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("after_reset_rsp_valid", int'(rsp_valid), 0);

      // 2: single job
      issue(0, 8'd48, 8'd36, 8'd12);
      check("single_gcd_a", int'(gcd_a), 48);
      check("single_gcd_b", int'(gcd_b), 36);
      drain();
      check("single_gcd_a_hold", int'(gcd_a), 48);

      // 3: fairness from a fresh pointer
      do_reset();
      st = glog.size();
      set_req(0, 8'd10, 8'd4, 8'd2);
      set_req(1, 8'd9, 8'd6, 8'd3);
      set_req(2, 8'd35, 8'd25, 8'd5);
      set_req(3, 8'd8, 8'd12, 8'd4);
      n = 0;
      while (glog.size() < st + 5 && n < 200) begin
         tick();
         n++;
      end
      vld = '0;
      ord = '{0, 1, 2, 3, 0};
      if (glog.size() < st + 5) check("fair_timeout", glog.size() - st, 5);
      else for (int k = 0; k < 5; k++) check("fair_order", glog[st + k], ord[k]);
      drain();

      // 4: back-pressure holds the response and blocks new grants
      rsp_ready = 1'b0;
      issue(1, 8'd21, 8'd14, 8'd7);
      st = hs_cnt[3];
      set_req(3, 8'd9, 8'd3, 8'd3);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      for (int k = 0; k < 10; k++) tick();
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_rsp_gcd", int'(rsp_gcd), 7);
      check("bp_rsp_id", int'(rsp_id), 1);
      check("bp_no_grant", hs_cnt[3], st);
      rsp_ready = 1'b1;
      wait_hs(3, st);
      drain();

      // 5: zero operands bypass the datapath
      issue(2, 8'd0, 8'd45, 8'd45);
      check("zero_rsp_valid", int'(rsp_valid), 1);
      check("zero_rsp_gcd", int'(rsp_gcd), 45);
      check("zero_rsp_id", int'(rsp_id), 2);
      check("zero_gcd_b", int'(gcd_b), 45);
      drain();
      issue(2, 8'd0, 8'd0, 8'd0);
      check("zero0_rsp_gcd", int'(rsp_gcd), 0);
      drain();

      // 6: random traffic and back-pressure
      for (int i = 0; i < N; i++) begin
         seen[i] = hs_cnt[i];
         hs0[i] = hs_cnt[i];
         rs0[i] = rsp_cnt[i];
      end
      issued = 0;
      got = 0;
      n = 0;
      while (got < 500 && n < 20000) begin
         tick();
         n++;
         for (int i = 0; i < N; i++) begin
            if (vld[i] && hs_cnt[i] != seen[i]) begin
               seen[i] = hs_cnt[i];
               vld[i] = 1'b0;
               got++;
            end
            if (!vld[i] && issued < 500 && $urandom_range(0, 2) == 0) begin
               a = 8'($urandom);
               b = 8'($urandom);
               if ($urandom_range(0, 7) == 0) a = 8'd0;
               if ($urandom_range(0, 7) == 0) b = 8'd0;
               set_req(i, a, b, ref_gcd(a, b));
               issued++;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (got < 500) check("rand_timeout", got, 500);
      rsp_ready = 1'b1;
      drain();
      for (int i = 0; i < N; i++)
         check("rand_jobs_per_id", rsp_cnt[i] - rs0[i], hs_cnt[i] - hs0[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
